// File: rtl/axi_lite_periph_responder_pkg.sv
// Shared types and constants for the AXI4-Lite peripheral responder:
// response codes, handshake FSM state encodings and the register width.
package axi_lite_periph_responder_pkg;

    localparam int REG_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_WAIT_D = 2'd1,
        W_WAIT_A = 2'd2,
        W_RESP   = 2'd3
    } wrState_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } rdState_t;

endpackage

// File: rtl/axi_lite_periph_responder_if.sv
// AXI4-Lite bus bundle between the CPU peripheral-access controller and
// the responder. master: initiator side, slave: responder side.
interface axi_lite_periph_responder_if #(
    parameter int ADDR_W = 8
);
    import axi_lite_periph_responder_pkg::*;

    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [REG_W-1:0]  S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [REG_W-1:0]  S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/axi_lite_periph_responder_periph_reg_file.sv
// periph_reg_file: register storage with byte-strobe merge, AXI-over-HW
// priority per byte, RegWrPulse generation and the read mux.
// Ports: Clk/Rst, AXI commit (axiWr*), hardware write-back (hwWr*),
// read index/data, flattened RegOut and RegWrPulse.
module periph_reg_file
    import axi_lite_periph_responder_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 6
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      axiWrEn,
    input  logic [IDX_W-1:0]          axiWrIdx,
    input  logic [REG_W-1:0]          axiWrData,
    input  logic [3:0]                axiWrStrb,
    input  logic                      hwWrEn,
    input  logic [5:0]                hwWrIdx,
    input  logic [REG_W-1:0]          hwWrData,
    input  logic [IDX_W-1:0]          rdIdx,
    output logic [REG_W-1:0]          rdData,
    output logic [NUM_REGS*REG_W-1:0] RegOut,
    output logic [NUM_REGS-1:0]       RegWrPulse
);

    logic [REG_W-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] axiHit;
    logic [NUM_REGS-1:0] hwHit;

    // Equality against an in-range index doubles as the range check.
    always_comb begin
        axiHit = '0;
        hwHit  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            axiHit[i] = axiWrEn && (axiWrIdx == IDX_W'(i));
            hwHit[i]  = hwWrEn && (hwWrIdx == 6'(i));
        end
    end

    // Strobed bytes take AXI data; otherwise HW write-back may fill them.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            RegWrPulse <= '0;
        end else begin
            RegWrPulse <= axiHit;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (axiHit[i] && axiWrStrb[b]) begin
                        regs[i][8*b +: 8] <= axiWrData[8*b +: 8];
                    end else if (hwHit[i]) begin
                        regs[i][8*b +: 8] <= hwWrData[8*b +: 8];
                    end
                end
            end
        end
    end

    // Out-of-range index matches nothing and reads as zero.
    always_comb begin
        rdData = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rdIdx == IDX_W'(i)) begin
                rdData = regs[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gOut
        assign RegOut[g*REG_W +: REG_W] = regs[g];
    end

endmodule

// File: rtl/axi_lite_periph_responder.sv
// AXI4-Lite responder holding NUM_REGS 32-bit peripheral registers.
// Ports: Clk, Rst (async high), axi (slave modport), RegOut, RegWrPulse,
// HwWrEn/HwWrIdx/HwWrData. Define AXI_SLV_ERR_EN for SLVERR on
// out-of-range accesses; otherwise they answer OKAY.
module axi_lite_periph_responder
    import axi_lite_periph_responder_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 8
) (
    input  logic                      Clk,
    input  logic                      Rst,
    axi_lite_periph_responder_if.slave axi,
    output logic [NUM_REGS*REG_W-1:0] RegOut,
    output logic [NUM_REGS-1:0]       RegWrPulse,
    input  logic                      HwWrEn,
    input  logic [5:0]                HwWrIdx,
    input  logic [REG_W-1:0]          HwWrData
);

    localparam int IDX_W = ADDR_W - 2;

`ifdef AXI_SLV_ERR_EN
    localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

    // Holds all readies low during reset and until the first clock after.
    logic readyEn;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) readyEn <= 1'b0;
        else     readyEn <= 1'b1;
    end

    logic unusedAddrBits;
    assign unusedAddrBits = ^{axi.S_AXI_AWADDR[1:0], axi.S_AXI_ARADDR[1:0]};

    // ---------------- write channel ----------------
    wrState_t         wrState;
    wrState_t         wrNext;
    logic             awReady;
    logic             wReady;
    logic             awHs;
    logic             wHs;
    logic             commit;
    logic [IDX_W-1:0] awIdxQ;
    logic [REG_W-1:0] wDataQ;
    logic [3:0]       wStrbQ;
    logic [IDX_W-1:0] cIdx;
    logic [REG_W-1:0] cData;
    logic [3:0]       cStrb;
    logic             cInRange;
    logic [1:0]       bResp;

    assign awReady = readyEn && (wrState == W_IDLE || wrState == W_WAIT_A);
    assign wReady  = readyEn && (wrState == W_IDLE || wrState == W_WAIT_D);
    assign awHs    = awReady && axi.S_AXI_AWVALID;
    assign wHs     = wReady && axi.S_AXI_WVALID;

    // Pick live bus values or the half latched in an earlier cycle.
    assign cIdx  = (wrState == W_WAIT_D) ? awIdxQ
                                          : axi.S_AXI_AWADDR[ADDR_W-1:2];
    assign cData = (wrState == W_WAIT_A) ? wDataQ : axi.S_AXI_WDATA;
    assign cStrb = (wrState == W_WAIT_A) ? wStrbQ : axi.S_AXI_WSTRB;
    assign cInRange = {1'b0, cIdx} < (IDX_W + 1)'(NUM_REGS);

    always_comb begin
        wrNext = wrState;
        commit = 1'b0;
        unique case (wrState)
            W_IDLE: begin
                if (awHs && wHs) begin
                    commit = 1'b1;
                    wrNext = W_RESP;
                end else if (awHs) begin
                    wrNext = W_WAIT_D;
                end else if (wHs) begin
                    wrNext = W_WAIT_A;
                end
            end
            W_WAIT_D: begin
                if (wHs) begin
                    commit = 1'b1;
                    wrNext = W_RESP;
                end
            end
            W_WAIT_A: begin
                if (awHs) begin
                    commit = 1'b1;
                    wrNext = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.S_AXI_BREADY) wrNext = W_IDLE;
            end
            default: wrNext = W_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wrState <= W_IDLE;
            awIdxQ  <= '0;
            wDataQ  <= '0;
            wStrbQ  <= '0;
            bResp   <= RESP_OKAY;
        end else begin
            wrState <= wrNext;
            if (awHs) awIdxQ <= axi.S_AXI_AWADDR[ADDR_W-1:2];
            if (wHs) begin
                wDataQ <= axi.S_AXI_WDATA;
                wStrbQ <= axi.S_AXI_WSTRB;
            end
            if (commit) bResp <= cInRange ? RESP_OKAY : RESP_OOR;
        end
    end

    assign axi.S_AXI_AWREADY = awReady;
    assign axi.S_AXI_WREADY  = wReady;
    assign axi.S_AXI_BVALID  = (wrState == W_RESP);
    assign axi.S_AXI_BRESP   = bResp;

    // ---------------- read channel ----------------
    rdState_t         rdState;
    rdState_t         rdNext;
    logic             arReady;
    logic             arHs;
    logic [IDX_W-1:0] arIdx;
    logic             arInRange;
    logic [REG_W-1:0] rdWord;
    logic [REG_W-1:0] rData;
    logic [1:0]       rResp;

    assign arReady   = readyEn && (rdState == R_IDLE);
    assign arHs      = arReady && axi.S_AXI_ARVALID;
    assign arIdx     = axi.S_AXI_ARADDR[ADDR_W-1:2];
    assign arInRange = {1'b0, arIdx} < (IDX_W + 1)'(NUM_REGS);

    always_comb begin
        rdNext = rdState;
        unique case (rdState)
            R_IDLE:  if (arHs) rdNext = R_VALID;
            R_VALID: if (axi.S_AXI_RREADY) rdNext = R_IDLE;
            default: rdNext = R_IDLE;
        endcase
    end

    // rdWord reflects pre-edge contents, so same-edge writes read old data.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rdState <= R_IDLE;
            rData   <= '0;
            rResp   <= RESP_OKAY;
        end else begin
            rdState <= rdNext;
            if (arHs) begin
                rData <= rdWord;
                rResp <= arInRange ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    assign axi.S_AXI_ARREADY = arReady;
    assign axi.S_AXI_RVALID  = (rdState == R_VALID);
    assign axi.S_AXI_RDATA   = rData;
    assign axi.S_AXI_RRESP   = rResp;

    periph_reg_file #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) uRegFile (
        .Clk        (Clk),
        .Rst        (Rst),
        .axiWrEn    (commit),
        .axiWrIdx   (cIdx),
        .axiWrData  (cData),
        .axiWrStrb  (cStrb),
        .hwWrEn     (HwWrEn),
        .hwWrIdx    (HwWrIdx),
        .hwWrData   (HwWrData),
        .rdIdx      (arIdx),
        .rdData     (rdWord),
        .RegOut     (RegOut),
        .RegWrPulse (RegWrPulse)
    );

endmodule

// File: tb/tb_axi_lite_periph_responder.sv
// Scoreboard bench for axi_lite_periph_responder: directed stimulus pushes
// expected B/R responses; a negedge monitor pops and compares them.
module tb_axi_lite_periph_responder;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 8;

`ifdef AXI_SLV_ERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    axi_lite_periph_responder_if #(.ADDR_W(ADDR_W)) bus ();

    logic [NUM_REGS*32-1:0] RegOut;
    logic [NUM_REGS-1:0]    RegWrPulse;
    logic                   HwWrEn = 1'b0;
    logic [5:0]             HwWrIdx = '0;
    logic [31:0]            HwWrData = '0;

    axi_lite_periph_responder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .axi        (bus),
        .RegOut     (RegOut),
        .RegWrPulse (RegWrPulse),
        .HwWrEn     (HwWrEn),
        .HwWrIdx    (HwWrIdx),
        .HwWrData   (HwWrData)
    );

    int nCmp = 0;
    int nErr = 0;
    logic [1:0]  expB [$];
    logic [33:0] expR [$];
    logic [31:0] model [NUM_REGS];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_REGS*32-1:0] image();
        logic [NUM_REGS*32-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic checkRegs(input string name);
        check(name, RegOut, image());
    endtask

    // Monitor: compare each completed response against the scoreboard.
    always @(negedge Clk) begin
        if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            if (expB.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", bus.S_AXI_BRESP, expB.pop_front());
        end
        if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            if (expR.size() == 0) check("r_unexpected", 1, 0);
            else check("rresp_rdata", {bus.S_AXI_RRESP, bus.S_AXI_RDATA},
                       expR.pop_front());
        end
    end

    task automatic axiWrite(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        bit aw = 0;
        bit w = 0;
        expB.push_back(resp);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 20 && !(aw && w); i++) begin
            @(negedge Clk);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw = 1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w = 1;
            @(posedge Clk);
            #1;
            if (aw) bus.S_AXI_AWVALID = 1'b0;
            if (w) bus.S_AXI_WVALID = 1'b0;
        end
        if (!(aw && w)) check("write_timeout", 0, 1);
    endtask

    task automatic axiRead(input logic [7:0] a, input logic [33:0] exp);
        bit ok = 0;
        expR.push_back(exp);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge Clk);
            if (bus.S_AXI_ARREADY) ok = 1;
            @(posedge Clk);
            #1;
            if (ok) bus.S_AXI_ARVALID = 1'b0;
        end
        if (!ok) check("read_timeout", 0, 1);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 0;
        bus.S_AXI_BREADY = 1; bus.S_AXI_ARADDR = '0;
        bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 1;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                              bus.S_AXI_ARREADY}, 3'b000);
        check("rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID,
                             bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 6'd0);
        check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
        check("rst_pulse", RegWrPulse, 8'h00);
        checkRegs("rst_regs");
        Rst = 1'b0;
        tick();
        check("ready_after_rst", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                                  bus.S_AXI_ARREADY}, 3'b111);

        // AW+W together to reg1
        axiWrite(8'h04, 32'hDEADBEEF, 4'hF, 2'b00);
        model[1] = 32'hDEADBEEF;
        check("t1_pulse", RegWrPulse, 8'b0000_0010);
        check("t1_bvalid", bus.S_AXI_BVALID, 1'b1);
        checkRegs("t1_regs");
        tick();
        check("t1_pulse_clear", RegWrPulse, 8'h00);

        // W first, AW three cycles later, partial strobe on reg2
        axiWrite(8'h08, 32'hAABBCCDD, 4'hF, 2'b00);
        model[2] = 32'hAABBCCDD;
        tick();
        expB.push_back(2'b00);
        bus.S_AXI_WDATA = 32'h11223344;
        bus.S_AXI_WSTRB = 4'b0101;
        bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("t2_wait_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                                    bus.S_AXI_BVALID}, 3'b100);
        end
        tick();
        bus.S_AXI_AWADDR = 8'h08;
        bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        model[2] = 32'hAA22CC44;
        checkRegs("t2_regs");
        check("t2_pulse", RegWrPulse, 8'b0000_0100);
        check("t2_bvalid", bus.S_AXI_BVALID, 1'b1);
        tick();

        // Stalled B channel
        bus.S_AXI_BREADY = 1'b0;
        axiWrite(8'h10, 32'h12345678, 4'hF, 2'b00);
        model[4] = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check("t3_stall", {bus.S_AXI_BVALID, bus.S_AXI_BRESP,
                               bus.S_AXI_AWREADY, bus.S_AXI_WREADY},
                  5'b1_00_00);
        end
        tick();
        bus.S_AXI_BREADY = 1'b1;
        tick();
        check("t3_release", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY,
                             bus.S_AXI_WREADY}, 3'b011);
        checkRegs("t3_regs");

        // Read held by RREADY=0 while HW overwrites reg1
        bus.S_AXI_RREADY = 1'b0;
        axiRead(8'h04, {2'b00, 32'hDEADBEEF});
        HwWrEn = 1'b1; HwWrIdx = 6'd1; HwWrData = 32'h0BADF00D;
        tick();
        HwWrEn = 1'b0;
        model[1] = 32'h0BADF00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("t4_hold", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY,
                              bus.S_AXI_RDATA}, {2'b10, 32'hDEADBEEF});
        end
        check("t4_hw_nopulse", RegWrPulse, 8'h00);
        checkRegs("t4_regs");
        tick();
        bus.S_AXI_RREADY = 1'b1;
        tick();
        check("t4_rvalid_clear", bus.S_AXI_RVALID, 1'b0);

        // Out-of-range write and read
        axiWrite(8'h40, 32'hFFFFFFFF, 4'hF, EXP_OOR);
        check("t5_pulse", RegWrPulse, 8'h00);
        checkRegs("t5_regs");
        axiRead(8'h40, {EXP_OOR, 32'h0});
        tick();

        // HW index out of range is ignored
        HwWrEn = 1'b1; HwWrIdx = 6'd9; HwWrData = 32'h55555555;
        tick();
        HwWrEn = 1'b0;
        checkRegs("t6_hw_oor");

        // Same-edge AXI commit and HW write to reg3
        expB.push_back(2'b00);
        bus.S_AXI_AWADDR = 8'h0C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h00005678; bus.S_AXI_WSTRB = 4'b0011;
        bus.S_AXI_WVALID = 1'b1;
        HwWrEn = 1'b1; HwWrIdx = 6'd3; HwWrData = 32'hFFFF0000;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; HwWrEn = 1'b0;
        model[3] = 32'hFFFF5678;
        checkRegs("t6_collide");
        check("t6_pulse", RegWrPulse, 8'b0000_1000);
        tick();
        tick();

        // Reset while waiting for write data
        bus.S_AXI_AWADDR = 8'h18; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        check("t7_wait_d", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b01);
        Rst = 1'b1;
        #1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        check("t7_rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                               bus.S_AXI_BVALID}, 3'b000);
        checkRegs("t7_rst_regs");
        tick();
        tick();
        Rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("t7_no_bvalid", bus.S_AXI_BVALID, 1'b0);
        end
        tick();
        axiRead(8'h04, {2'b00, 32'h0});
        tick();
        tick();
        check("b_queue_empty", expB.size(), 0);
        check("r_queue_empty", expR.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nErr);
        $finish;
    end

endmodule
